seg_scan_mux: RTL and testbench

Time-multiplexed digit scanner for a multi-digit common-anode 7-segment display. Sits directly upstream of the 4-bit-to-7-segment decoder. It latches a packed hex value, walks through the digits at a programmable dwell rate, and presents one 4-bit nibble per dwell slot to the decoder while driving the matching active-low digit enable. The decoder's segment output and this block's digit enables together drive the display pins.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/scan_prescaler.sv | 28 ++
 rtl/seg_scan_mux.sv | 78 +++++++
 tb/tb_seg_scan_mux.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan logic.
package seg_pkg;

    localparam int NIB_W            = 4;
    localparam int DEFAULT_DIGITS   = 4;
    localparam int DEFAULT_SCAN_DIV = 50000;
    localparam int MAX_DIGITS       = 8;

    // Active-low one-hot enable; bits at or above n stay high (off).
    function automatic logic [MAX_DIGITS-1:0] digit_on_n(input int unsigned idx,
                                                         input int unsigned n);
        logic [MAX_DIGITS-1:0] en_n;
        en_n = '1;
        for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
            if (d == idx && d < n)
                en_n[d] = 1'b0;
        end
        return en_n;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell-rate prescaler: counts 0..SCAN_DIV-1 and flags the last count.
module scan_prescaler
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count_q;

    assign tick = (count_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst)
            count_q <= '0;
        else if (tick)
            count_q <= '0;
        else
            count_q <= count_q + CNT_W'(1);
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit scanner feeding a 7-segment decoder.
// Define LZ_BLANK_EN to suppress leading-zero digits.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_DIGITS,
    parameter int SCAN_DIV   = DEFAULT_SCAN_DIV
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [NIB_W*NUM_DIGITS-1:0]   data_in,
    input  logic                          blank,
    output logic [NIB_W-1:0]              nib_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [NIB_W*NUM_DIGITS-1:0] hold_q;
    logic [IDX_W-1:0]            idx_q;
    logic                        tick;
    logic [NUM_DIGITS-1:0]       on_n;
    logic [NUM_DIGITS-1:0]       lz_mask;
    logic [NUM_DIGITS-1:0]       an_next;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign on_n = NUM_DIGITS'(digit_on_n(32'(idx_q), NUM_DIGITS));

`ifdef LZ_BLANK_EN
    // A digit is dark when it and every digit above it hold zero; digit 0 always shows.
    always_comb begin : lz_scan
        logic upper_zero;
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            upper_zero = upper_zero && (hold_q[NIB_W*d +: NIB_W] == '0);
            lz_mask[d] = upper_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign an_next = blank ? '1 : (on_n | lz_mask);

    // Nibble and enable share one register stage so digit switches never ghost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q     <= '0;
            idx_q      <= '0;
            nib_out    <= '0;
            an_out     <= '1;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (load)
                hold_q <= data_in;
            if (tick)
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            frame_done <= tick && (idx_q == LAST_IDX);
            nib_out    <= hold_q[NIB_W*idx_q +: NIB_W];
            an_out     <= an_next;
            digit_idx  <= idx_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux with 4 digits and a dwell of 4 cycles.
module tb_seg_scan_mux;

    localparam int ND = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  nib_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          last_fd = -1;
    int          guard;
    logic [15:0] hold_m = '0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .blank      (blank),
        .nib_out    (nib_out),
        .an_out     (an_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Expected enables: only digit d lit, dark when blanked or (with LZ) above the top non-zero nibble.
    function automatic logic [3:0] expAn(input int d, input logic [15:0] h, input logic b);
        logic [3:0] en;
        int msd;
        if (b)
            return 4'hF;
        en    = 4'hF;
        en[d] = 1'b0;
        msd   = 0;
`ifdef LZ_BLANK_EN
        for (int k = 0; k < ND; k++)
            if (h[4*k +: 4] != 4'h0)
                msd = k;
        if (d > msd)
            en = 4'hF;
`else
        if (h == 16'hFFFF && msd != 0)
            en = 4'hF;
`endif
        return en;
    endfunction

    task automatic applyStimulus(input logic ld, input logic [15:0] data, input logic bl);
        load    = ld;
        data_in = data;
        blank   = bl;
    endtask

    // Digit shown after edge n (counted from reset release) is ((n-1)/SD) mod ND.
    task automatic runCycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [15:0] next_h;
            logic        bl;
            int          d;
            next_h = load ? data_in : hold_m;
            bl     = blank;
            @(negedge clk);
            edge_n++;
            d = ((edge_n - 1) / SD) % ND;
            checkOutput("digit_idx", 32'(digit_idx), 32'(d));
            checkOutput("nib_out", 32'(nib_out), 32'(hold_m[4*d +: 4]));
            checkOutput("an_out", 32'(an_out), 32'(expAn(d, hold_m, bl)));
            checkOutput("frame_done", 32'(frame_done), 32'((edge_n % (ND*SD)) == 0));
            if (frame_done) begin
                if (last_fd >= 0)
                    checkOutput("frame_gap", 32'(edge_n - last_fd), 32'(ND*SD));
                last_fd = edge_n;
            end
            hold_m = next_h;
            load   = 1'b0;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_an"},   32'(an_out),     32'hF);
        checkOutput({tag, "_nib"},  32'(nib_out),    32'h0);
        checkOutput({tag, "_fd"},   32'(frame_done), 32'h0);
        checkOutput({tag, "_idx"},  32'(digit_idx),  32'h0);
    endtask

    initial begin
        // Power-up reset held for three edges
        repeat (3) begin
            @(negedge clk);
            checkResetState("rst");
        end
        rst = 1'b1;
        edge_n = 0; hold_m = '0; last_fd = -1;
        runCycles(1);
        checkOutput("first_an", 32'(an_out), 32'b1110);

        // Full scan of 1A3F over two frames
        applyStimulus(1'b1, 16'h1A3F, 1'b0);
        runCycles(35);

        // Load during the second cycle of digit 0's dwell
        runCycles(14);
        applyStimulus(1'b1, 16'h0005, 1'b0);
        runCycles(2);
        checkOutput("mid_load_nib", 32'(nib_out), 32'h5);
        runCycles(13);

        // Blank for six cycles, then confirm the scan resumes on digit 2
        applyStimulus(1'b1, 16'h1A3F, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        runCycles(6);
        checkOutput("blank_an", 32'(an_out), 32'hF);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        runCycles(1);
        checkOutput("blank_resume_an", 32'(an_out), 32'b1011);
        checkOutput("blank_resume_idx", 32'(digit_idx), 32'd2);
        runCycles(9);

        // Leading-zero patterns
        applyStimulus(1'b1, 16'h0050, 1'b0);
        runCycles(17);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        runCycles(17);

        // Reset asserted while digit 2 is displayed, with load and blank active
        guard = 0;
        while (digit_idx != 2'd2 && guard < 20) begin
            runCycles(1);
            guard++;
        end
        checkOutput("find_idx2", 32'(digit_idx), 32'd2);
        rst = 1'b0;
        applyStimulus(1'b1, 16'hFFFF, 1'b1);
        @(negedge clk);
        checkResetState("midrst");
        applyStimulus(1'b1, 16'hFFFF, 1'b0);
        @(negedge clk);
        checkResetState("midrst2");
        applyStimulus(1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        edge_n = 0; hold_m = '0; last_fd = -1;
        runCycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
